// File: rtl/w_74hc283.sv
// w_74hc283: registered 4-bit binary full adder with look-ahead carry.
// It also produces group propagate/generate terms so that an external
// look-ahead unit can chain several of these cells into a wider adder.
module w_74hc283 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       in,
   output logic [3:0] sum,
   output logic       out,
   output logic       pg,
   output logic       gg
);

   logic [3:0] p, g;
   logic [4:0] c;
   logic [3:0] sum_d, sum_q;
   logic       out_d, out_q;
   logic       pg_d, pg_q;
   logic       gg_d, gg_q;

   // Per-bit terms, flattened carry look-ahead (no ripple chain), sum and group terms
   always_comb begin
      p = a ^ b;
      g = a & b;
      c[0] = in;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum_d = p ^ c[3:0];
      out_d = c[4];
      pg_d  = &p;
      gg_d  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
   end

   // Output registers; reset wins over a same-edge operand capture
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= 4'b0000;
         out_q <= 1'b0;
         pg_q  <= 1'b0;
         gg_q  <= 1'b0;
      end else begin
         sum_q <= sum_d;
         out_q <= out_d;
         pg_q  <= pg_d;
         gg_q  <= gg_d;
      end
   end

   assign sum = sum_q;
   assign out = out_q;
   assign pg  = pg_q;
   assign gg  = gg_q;

endmodule

// File: tb/tb_w_74hc283.sv
// Bench for w_74hc283: directed table, sweeps, exhaustive, random and
// mid-stream reset sequences against an arithmetic reference model.
module tb_w_74hc283;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a, b;
   logic       in;
   logic [3:0] sum;
   logic       out, pg, gg;

   int checks = 0;
   int errors = 0;

   w_74hc283 dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .in(in),
      .sum(sum), .out(out), .pg(pg), .gg(gg)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [3:0] s;
      logic       co;
      logic       pg;
      logic       gg;
      logic       chk_grp;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer addition; the group terms follow from a+b alone
   task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mc,
                        output logic [3:0] s, output logic co,
                        output logic mpg, output logic mgg);
      int t, ab;
      ab  = int'(ma) + int'(mb);
      t   = ab + int'(mc);
      s   = 4'(t % 16);
      co  = (t > 15);
      mpg = (ab == 15);
      mgg = (ab > 15);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Apply operands, wait one edge, compare everything against the model
   task automatic apply_chk(input string nm, input logic [3:0] va, input logic [3:0] vb,
                            input logic vc);
      logic [3:0] es;
      logic eo, ep, eg;
      a = va; b = vb; in = vc; rst = 1'b0;
      step();
      model(va, vb, vc, es, eo, ep, eg);
      chk({nm, ".sumout"}, {3'b0, out, sum}, {3'b0, eo, es});
      chk({nm, ".pg"}, {7'b0, pg}, {7'b0, ep});
      chk({nm, ".gg"}, {7'b0, gg}, {7'b0, eg});
      chk({nm, ".cons"}, {7'b0, out}, {7'b0, gg | (pg & vc)});
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {2'b0, gg, pg, out, sum}, 8'h00);
   endtask

   initial begin
      logic [3:0] hs;
      logic [3:0] ra, rb;
      logic       rc;

      // name, rst, a, b, ci, s, co, pg, gg, chk_grp
      tbl.push_back('{"rst_hold",  1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{"rst_rel",   1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{"sw0_b0",    1'b0, 4'h4, 4'd0,  1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw0_b11",   1'b0, 4'h4, 4'd11, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw0_b12",   1'b0, 4'h4, 4'd12, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw0_b15",   1'b0, 4'h4, 4'd15, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw1_b0",    1'b0, 4'h4, 4'd0,  1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw1_b10",   1'b0, 4'h4, 4'd10, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw1_b11",   1'b0, 4'h4, 4'd11, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"sw1_b15",   1'b0, 4'h4, 4'd15, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{"grp_p",     1'b0, 4'hA, 4'h5, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{"grp_p_c1",  1'b0, 4'hA, 4'h5, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{"grp_g",     1'b0, 4'h8, 4'h8, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1});

      rst = 1'b1; a = 4'hF; b = 4'hF; in = 1'b1;

      // Directed table
      foreach (tbl[i]) begin
         rst = tbl[i].rst; a = tbl[i].a; b = tbl[i].b; in = tbl[i].ci;
         step();
         chk({tbl[i].name, ".sum"}, {4'b0, sum}, {4'b0, tbl[i].s});
         chk({tbl[i].name, ".out"}, {7'b0, out}, {7'b0, tbl[i].co});
         if (tbl[i].chk_grp) begin
            chk({tbl[i].name, ".pg"}, {7'b0, pg}, {7'b0, tbl[i].pg});
            chk({tbl[i].name, ".gg"}, {7'b0, gg}, {7'b0, tbl[i].gg});
         end
      end

      // Full sweeps, a = 4, b = 0..15, both carry-ins
      for (int ci = 0; ci < 2; ci++)
         for (int j = 0; j < 16; j++)
            apply_chk($sformatf("sweep_c%0d_b%0d", ci, j), 4'h4, 4'(j), 1'(ci));

      // Exhaustive 512 combinations, one per cycle
      for (int k = 0; k < 512; k++)
         apply_chk($sformatf("exh_%0d", k), 4'(k >> 5), 4'(k >> 1), 1'(k));

      // Outputs hold between edges even when inputs move
      apply_chk("hold_pre", 4'h7, 4'h6, 1'b1);
      hs = sum;
      a = 4'h1; b = 4'h2; in = 1'b0;
      #3;
      chk("hold_sum", {3'b0, out, sum}, {3'b0, 1'b0, hs});

      // Reset mid-stream: zero for exactly the reset cycle, then normal results
      for (int j = 0; j < 16; j++) begin
         if (j == 7) begin
            a = 4'h9; b = 4'(j); in = 1'b1; rst = 1'b1;
            step();
            chk_zero("mid_rst_zero");
         end else begin
            apply_chk($sformatf("mid_rst_b%0d", j), 4'h9, 4'(j), 1'b1);
         end
      end

      // Random operands
      for (int r = 0; r < 300; r++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         apply_chk($sformatf("rnd_%0d", r), ra, rb, rc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
